float_scale_ctrl: RTL and testbench

Automatic scale controller for the float_rounder offset input. It watches the same sample stream the rounder consumes and measures the peak bit occupancy over fixed-length blocks. At each block boundary it chooses the offset that keeps the output window on the most significant occupied bit. Decreases take effect immediately (attack); increases happen one step at a time, only after a programmable number of quiet blocks (release hysteresis).

---
 rtl/float_scale_ctrl_if.sv | 39 +++
 rtl/float_scale_ctrl.sv | 166 ++++++++++++++++
 tb/tb_float_scale_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_scale_ctrl_if.sv
// -----------------------------------------------------------------------------
// float_scale_ctrl_if
//   Bundles the sample stream, control inputs and offset outputs of
//   float_scale_ctrl. clk and rst are kept as plain ports on the block.
//
//   clkena       clock enable; nothing in the controller moves while it is 0
//   i_valid      i_data qualifier
//   i_data       sample (same stream the float_rounder consumes)
//   ctrl_freeze  hold the offset; measurement keeps running
//   ctrl_load    one-cycle force-load of the offset
//   ctrl_offset  value used by ctrl_load (clamped to IWIDTH-OWIDTH)
//   o_offset     offset towards float_rounder
//   o_update     one-cycle pulse per block decision
// -----------------------------------------------------------------------------
interface float_scale_ctrl_if #(
    parameter int IWIDTH = 7,
    parameter int OWIDTH = 4
);
    localparam int OFFW = $clog2(IWIDTH - OWIDTH + 1);

    logic              clkena;
    logic              i_valid;
    logic [IWIDTH-1:0] i_data;
    logic              ctrl_freeze;
    logic              ctrl_load;
    logic [OFFW-1:0]   ctrl_offset;
    logic [OFFW-1:0]   o_offset;
    logic              o_update;

    modport master (
        output clkena, i_valid, i_data, ctrl_freeze, ctrl_load, ctrl_offset,
        input  o_offset, o_update
    );

    modport slave (
        input  clkena, i_valid, i_data, ctrl_freeze, ctrl_load, ctrl_offset,
        output o_offset, o_update
    );
endinterface

// File: rtl/float_scale_ctrl.sv
// -----------------------------------------------------------------------------
// float_scale_ctrl
//   Automatic scale controller for the float_rounder offset. ORs the samples
//   of each BLKLEN-sample block into an occupancy mask, turns the mask into a
//   leading-zero count and picks the offset that keeps the rounder window on
//   the most significant occupied bit. Smaller offsets are taken at once;
//   larger ones are approached one step per HOLD consecutive requesting blocks.
//
//   Ports:
//     clk   clock
//     rst   asynchronous, active-low reset
//     bus   float_scale_ctrl_if.slave (clkena, sample stream, control, outputs)
//
//   Pipeline (enabled cycles): last sample T -> mask T+1 -> cand T+2 ->
//   o_offset / o_update T+3.
// -----------------------------------------------------------------------------
module float_scale_ctrl #(
    parameter int    IWIDTH  = 7,
    parameter int    OWIDTH  = 4,
    parameter string SIGNREP = "UNSIGNED",
    parameter int    BLKLEN  = 16,
    parameter int    HOLD    = 4
) (
    input logic                clk,
    input logic                rst,
    float_scale_ctrl_if.slave  bus
);
    localparam int OFFW      = $clog2(IWIDTH - OWIDTH + 1);
    localparam int MAXOFF    = IWIDTH - OWIDTH;
    localparam int CNTW      = $clog2(BLKLEN);
    localparam int HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam bit IS_SIGNED = (SIGNREP == "SIGNED");

    logic [IWIDTH-1:0] acc_q,     acc_d;
    logic [CNTW-1:0]   cnt_q,     cnt_d;
    logic              s1_vld_q,  s1_vld_d;
    logic [IWIDTH-1:0] s1_mask_q, s1_mask_d;
    logic              s2_vld_q,  s2_vld_d;
    logic [OFFW-1:0]   s2_cand_q, s2_cand_d;
    logic [OFFW-1:0]   off_q,     off_d;
    logic [HCW-1:0]    hcnt_q,    hcnt_d;
    logic              upd_q,     upd_d;

    logic [IWIDTH-1:0] m;
    logic [OFFW-1:0]   load_val;

    // Leading-zero count clamped to MAXOFF. In signed mode the sign bit of the
    // mask is always cleared, so the full-width count is exactly one larger
    // than the count over [IWIDTH-2:0] (including the all-zero case).
    function automatic logic [OFFW-1:0] cand_of(input logic [IWIDTH-1:0] mask);
        int lz;
        lz = IWIDTH;
        for (int i = 0; i < IWIDTH; i++) begin
            if (mask[i]) lz = IWIDTH - 1 - i;
        end
        if (IS_SIGNED) lz = lz - 1;
        if (lz > MAXOFF) lz = MAXOFF;
        return OFFW'(lz);
    endfunction

    // Occupancy contribution of one sample: magnitude bits only when signed.
    always_comb begin
        m = bus.i_data;
        if (IS_SIGNED) begin
            m = bus.i_data ^ {IWIDTH{bus.i_data[IWIDTH-1]}};
            m[IWIDTH-1] = 1'b0;
        end
    end

    assign load_val = (int'(bus.ctrl_offset) > MAXOFF) ? OFFW'(MAXOFF) : bus.ctrl_offset;

    // NOTE: every _d starts from its _q so no path leaves a variable unassigned;
    // that is what keeps this block free of inferred latches.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        s1_vld_d  = s1_vld_q;
        s1_mask_d = s1_mask_q;
        s2_vld_d  = s2_vld_q;
        s2_cand_d = s2_cand_q;
        off_d     = off_q;
        hcnt_d    = hcnt_q;
        upd_d     = upd_q;

        if (bus.clkena) begin
            // Pipeline advance; stage valids are single-cycle tokens.
            s1_vld_d  = 1'b0;
            s2_vld_d  = s1_vld_q;
            s2_cand_d = cand_of(s1_mask_q);
            upd_d     = s2_vld_q;

            if (s2_vld_q) begin
                if (bus.ctrl_freeze) begin
                    hcnt_d = '0;
                end else if (s2_cand_q < off_q) begin
                    off_d  = s2_cand_q;            // attack: jump straight down
                    hcnt_d = '0;
                end else if (s2_cand_q == off_q) begin
                    hcnt_d = '0;
                end else if (hcnt_q == HCW'(HOLD - 1)) begin
                    off_d  = off_q + 1'b1;         // release: one step per HOLD blocks
                    hcnt_d = '0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end

            if (bus.i_valid) begin
                if (cnt_q == CNTW'(BLKLEN - 1)) begin
                    // Close the block with this sample; next block starts empty.
                    s1_mask_d = acc_q | m;
                    s1_vld_d  = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    acc_d = acc_q | m;
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Force-load overrides everything above, including a decision
            // landing in the same cycle and a sample accepted in this cycle.
            if (bus.ctrl_load) begin
                acc_d    = '0;
                cnt_d    = '0;
                s1_vld_d = 1'b0;
                s2_vld_d = 1'b0;
                upd_d    = 1'b0;
                off_d    = load_val;
                hcnt_d   = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // register samples the values from before this edge regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the mask/candidate data registers are reset too even though
            // their valids already qualify them; it keeps X out of the pipeline.
            acc_q     <= '0;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_mask_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_cand_q <= '0;
            off_q     <= '0;
            hcnt_q    <= '0;
            upd_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_mask_q <= s1_mask_d;
            s2_vld_q  <= s2_vld_d;
            s2_cand_q <= s2_cand_d;
            off_q     <= off_d;
            hcnt_q    <= hcnt_d;
            upd_q     <= upd_d;
        end
    end

    assign bus.o_offset = off_q;
    assign bus.o_update = upd_q;

endmodule

// File: tb/tb_float_scale_ctrl.sv
// -----------------------------------------------------------------------------
// tb_float_scale_ctrl
//   Directed bench for float_scale_ctrl with IWIDTH=7, OWIDTH=4, BLKLEN=4,
//   HOLD=2 (MAXOFF=3). u_dut is the UNSIGNED instance, s_dut the SIGNED one;
//   both share clk, rst and clkena. Inputs change 1 time unit after the rising
//   edge and outputs are observed there as well.
// -----------------------------------------------------------------------------
module tb_float_scale_ctrl;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;
    bit slow     = 1'b0;   // clkena pattern 1010 when set
    bit sel      = 1'b0;   // 0: drive u_dut, 1: drive s_dut

    float_scale_ctrl_if #(.IWIDTH(7), .OWIDTH(4)) u_if ();
    float_scale_ctrl_if #(.IWIDTH(7), .OWIDTH(4)) s_if ();

    float_scale_ctrl #(
        .IWIDTH(7), .OWIDTH(4), .SIGNREP("UNSIGNED"), .BLKLEN(4), .HOLD(2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    float_scale_ctrl #(
        .IWIDTH(7), .OWIDTH(4), .SIGNREP("SIGNED"), .BLKLEN(4), .HOLD(2)
    ) s_dut (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ena(input logic e);
        u_if.clkena = e;
        s_if.clkena = e;
    endtask

    // One enabled cycle; in slow mode it is followed by one disabled cycle.
    task automatic en_cycle();
        set_ena(1'b1);
        tick();
        if (slow) begin
            set_ena(1'b0);
            tick();
        end
    endtask

    function automatic logic cur_upd();
        return sel ? s_if.o_update : u_if.o_update;
    endfunction

    function automatic logic [1:0] cur_off();
        return sel ? s_if.o_offset : u_if.o_offset;
    endfunction

    task automatic send(input logic [6:0] d);
        if (sel) begin
            s_if.i_valid = 1'b1;
            s_if.i_data  = d;
        end else begin
            u_if.i_valid = 1'b1;
            u_if.i_data  = d;
        end
        en_cycle();
        u_if.i_valid = 1'b0;
        s_if.i_valid = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] v);
        if (sel) begin
            s_if.ctrl_load   = 1'b1;
            s_if.ctrl_offset = v;
        end else begin
            u_if.ctrl_load   = 1'b1;
            u_if.ctrl_offset = v;
        end
        en_cycle();
        u_if.ctrl_load = 1'b0;
        s_if.ctrl_load = 1'b0;
    endtask

    // Called right after a block's last sample. lat counts enabled edges from
    // the accepting edge (inclusive) until o_update is seen; -1 on timeout.
    task automatic wait_update(output int lat, output logic [1:0] off,
                               output logic upd_after);
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            if (cur_upd() === 1'b1) begin
                lat = k;
                break;
            end
            en_cycle();
        end
        off = cur_off();
        en_cycle();
        upd_after = cur_upd();
    endtask

    task automatic run_block(input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3,
                             output int lat, output logic [1:0] off,
                             output logic upd_after);
        send(d0);
        send(d1);
        send(d2);
        send(d3);
        wait_update(lat, off, upd_after);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        int         lat;
        logic [1:0] off;
        logic       ua;
        logic       seen;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_ena(1'($urandom));
            u_if.i_valid     = 1'($urandom);
            u_if.i_data      = 7'($urandom);
            u_if.ctrl_load   = 1'($urandom);
            u_if.ctrl_offset = 2'($urandom);
            u_if.ctrl_freeze = 1'($urandom);
            s_if.i_valid     = 1'($urandom);
            s_if.i_data      = 7'($urandom);
            s_if.ctrl_load   = 1'($urandom);
            s_if.ctrl_offset = 2'($urandom);
            tick();
            checks++;
            if ({u_if.o_offset, u_if.o_update, s_if.o_offset, s_if.o_update} !== 6'b0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: outputs %b expected 000000", i,
                         {u_if.o_offset, u_if.o_update, s_if.o_offset, s_if.o_update});
            end
        end
        u_if.i_valid = 1'b0; u_if.ctrl_load = 1'b0; u_if.ctrl_freeze = 1'b0;
        s_if.i_valid = 1'b0; s_if.ctrl_load = 1'b0; s_if.ctrl_freeze = 1'b0;
        set_ena(1'b0);
        rst = 1'b1;

        // Three samples, then a valid gap: no decision may appear yet.
        sel = 1'b0;
        send(7'h01);
        send(7'h01);
        send(7'h01);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en_cycle();
            seen = seen | u_if.o_update;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_early_update: o_update seen=%b expected 0", seen);
        end
        send(7'h01);
        wait_update(lat, off, ua);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL reset_first_lat: got %0d expected 3", lat);
        end
        checks++;
        if (off !== 2'd0) begin
            failures++;
            $display("FAIL reset_first_off: got %0d expected 0", off);
        end
    endtask

    task automatic test_release();
        int         lat;
        logic [1:0] off;
        logic       ua;
        logic [1:0] exp_off [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        sel = 1'b0;
        do_load(2'd0);
        for (int b = 0; b < 7; b++) begin
            run_block(7'h01, 7'h02, 7'h03, 7'h01, lat, off, ua);
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("FAIL release_lat[%0d]: got %0d expected 3", b, lat);
            end
            checks++;
            if (off !== exp_off[b]) begin
                failures++;
                $display("FAIL release_off[%0d]: got %0d expected %0d", b, off, exp_off[b]);
            end
            checks++;
            if (ua !== 1'b0) begin
                failures++;
                $display("FAIL release_pulse[%0d]: o_update after pulse %b expected 0", b, ua);
            end
        end
    endtask

    task automatic test_attack();
        int         lat;
        logic [1:0] off;
        logic       ua;
        sel = 1'b0;
        run_block(7'h00, 7'h00, 7'h7F, 7'h00, lat, off, ua);
        checks++;
        if (lat !== 3 || off !== 2'd0) begin
            failures++;
            $display("FAIL attack_full: lat %0d off %0d expected lat 3 off 0", lat, off);
        end
        do_load(2'd3);
        checks++;
        if (u_if.o_offset !== 2'd3) begin
            failures++;
            $display("FAIL attack_load: got %0d expected 3", u_if.o_offset);
        end
        run_block(7'h10, 7'h00, 7'h00, 7'h00, lat, off, ua);
        checks++;
        if (lat !== 3 || off !== 2'd2) begin
            failures++;
            $display("FAIL attack_partial: lat %0d off %0d expected lat 3 off 2", lat, off);
        end
    endtask

    task automatic test_freeze();
        int         lat;
        logic [1:0] off;
        logic       ua;
        logic [1:0] exp_after [2] = '{2'd0, 2'd1};
        sel = 1'b0;
        do_load(2'd0);
        u_if.ctrl_freeze = 1'b1;
        for (int b = 0; b < 3; b++) begin
            run_block(7'h01, 7'h01, 7'h01, 7'h01, lat, off, ua);
            checks++;
            if (lat !== 3 || off !== 2'd0) begin
                failures++;
                $display("FAIL freeze_hold[%0d]: lat %0d off %0d expected lat 3 off 0", b, lat, off);
            end
        end
        u_if.ctrl_freeze = 1'b0;
        for (int b = 0; b < 2; b++) begin
            run_block(7'h01, 7'h01, 7'h01, 7'h01, lat, off, ua);
            checks++;
            if (lat !== 3 || off !== exp_after[b]) begin
                failures++;
                $display("FAIL freeze_release[%0d]: lat %0d off %0d expected lat 3 off %0d",
                         b, lat, off, exp_after[b]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] upd_vec;
        sel = 1'b0;
        do_load(2'd0);
        upd_vec = '0;
        for (int j = 0; j < 16; j++) begin
            if (j < 12) send(7'h01);
            else        en_cycle();
            upd_vec[j] = u_if.o_update;
        end
        checks++;
        if (upd_vec !== 16'h2220) begin
            failures++;
            $display("FAIL b2b_update_pattern: got %h expected 2220", upd_vec);
        end
        checks++;
        if (u_if.o_offset !== 2'd1) begin
            failures++;
            $display("FAIL b2b_offset: got %0d expected 1", u_if.o_offset);
        end
    endtask

    task automatic test_load_collision();
        int         lat;
        logic [1:0] off;
        logic       ua;
        logic       seen;
        sel = 1'b0;
        // Block with cand 0; load lands in the cycle its decision would.
        send(7'h7F);
        send(7'h00);
        send(7'h00);
        send(7'h00);
        en_cycle();
        do_load(2'd3);
        checks++;
        if (u_if.o_offset !== 2'd3 || u_if.o_update !== 1'b0) begin
            failures++;
            $display("FAIL collision_load: off %0d upd %b expected off 3 upd 0",
                     u_if.o_offset, u_if.o_update);
        end
        en_cycle();
        checks++;
        if (u_if.o_offset !== 2'd3 || u_if.o_update !== 1'b0) begin
            failures++;
            $display("FAIL collision_dropped: off %0d upd %b expected off 3 upd 0",
                     u_if.o_offset, u_if.o_update);
        end

        // Clock enable 1010 from here on; a partial block and the sample
        // accepted in the load cycle must both be discarded.
        slow = 1'b1;
        send(7'h7F);
        send(7'h7F);
        u_if.i_valid = 1'b1;
        u_if.i_data  = 7'h7F;
        do_load(2'd3);
        u_if.i_valid = 1'b0;
        checks++;
        if (u_if.o_offset !== 2'd3) begin
            failures++;
            $display("FAIL slow_load: got %0d expected 3", u_if.o_offset);
        end
        send(7'h01);
        send(7'h01);
        send(7'h01);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en_cycle();
            seen = seen | u_if.o_update;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL slow_early_update: o_update seen=%b expected 0", seen);
        end
        send(7'h01);
        wait_update(lat, off, ua);
        checks++;
        if (lat !== 3 || off !== 2'd3 || ua !== 1'b0) begin
            failures++;
            $display("FAIL slow_fresh_block: lat %0d off %0d after %b expected lat 3 off 3 after 0",
                     lat, off, ua);
        end
        run_block(7'h00, 7'h20, 7'h00, 7'h00, lat, off, ua);
        checks++;
        if (lat !== 3 || off !== 2'd1) begin
            failures++;
            $display("FAIL slow_attack: lat %0d off %0d expected lat 3 off 1", lat, off);
        end
        slow = 1'b0;
    endtask

    task automatic test_signed();
        int         lat;
        logic [1:0] off;
        logic       ua;
        logic [1:0] exp_zero [2] = '{2'd0, 2'd1};
        sel = 1'b1;
        do_load(2'd3);
        checks++;
        if (s_if.o_offset !== 2'd3) begin
            failures++;
            $display("FAIL signed_load: got %0d expected 3", s_if.o_offset);
        end
        run_block(7'h7F, 7'h00, 7'h7E, 7'h01, lat, off, ua);   // -1,0,-2,1
        checks++;
        if (lat !== 3 || off !== 2'd3) begin
            failures++;
            $display("FAIL signed_small: lat %0d off %0d expected lat 3 off 3", lat, off);
        end
        run_block(7'h40, 7'h00, 7'h00, 7'h00, lat, off, ua);   // -64,0,0,0
        checks++;
        if (lat !== 3 || off !== 2'd0) begin
            failures++;
            $display("FAIL signed_full: lat %0d off %0d expected lat 3 off 0", lat, off);
        end
        for (int b = 0; b < 2; b++) begin
            run_block(7'h7F, 7'h7F, 7'h7F, 7'h7F, lat, off, ua); // all -1: empty mask
            checks++;
            if (lat !== 3 || off !== exp_zero[b]) begin
                failures++;
                $display("FAIL signed_empty[%0d]: lat %0d off %0d expected lat 3 off %0d",
                         b, lat, off, exp_zero[b]);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        set_ena(1'b0);
        u_if.i_valid = 1'b0; u_if.i_data = '0; u_if.ctrl_freeze = 1'b0;
        u_if.ctrl_load = 1'b0; u_if.ctrl_offset = '0;
        s_if.i_valid = 1'b0; s_if.i_data = '0; s_if.ctrl_freeze = 1'b0;
        s_if.ctrl_load = 1'b0; s_if.ctrl_offset = '0;

        test_reset();
        test_release();
        test_attack();
        test_freeze();
        test_back_to_back();
        test_load_collision();
        test_signed();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
